// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC and fills a one-entry buffer for decode.
// Latency: request to valid is 1 cycle plus memory latency (2 cycles with a 1-cycle memory).
// Backpressure: no new request is issued while the buffer is full and decode stalls.
//
// Ports:
//   Clock, Reset                  - rising-edge clock, synchronous active-high reset
//   MemReadAddress/Request/Ready  - word fetch request channel (address = PC)
//   MemReadDataValid/Data         - returned instruction word
//   Instruction/InstructionPC/
//   InstructionValid/DecodeStall  - single-entry output buffer towards decode
//   Redirect/RedirectTarget       - branch/jump redirect from execute
//   MisalignedFetchSignal         - sticky flag: redirect target was not word aligned
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic        MemReadReady,
    input  logic        MemReadDataValid,
    input  logic [31:0] MemReadData,
    output logic [31:0] Instruction,
    output logic [31:0] InstructionPC,
    output logic        InstructionValid,
    input  logic        DecodeStall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        MisalignedFetchSignal
);

    typedef enum logic [1:0] {
        REQUEST   = 2'd0,
        WAIT_DATA = 2'd1,
        HALT      = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        discard;

    logic        buffer_blocked;
    logic        handshake;
    logic        target_misaligned;

    // A full buffer that decode is not draining must not be refilled, so the
    // request is held off; this guarantees a returning word always has room.
    assign buffer_blocked    = InstructionValid && DecodeStall;
    assign target_misaligned = (RedirectTarget[1:0] != 2'b00);

    assign MemReadAddress = pc;
    // A redirect cycle never issues: the old PC is stale and the new one is
    // only loaded on this edge.
    assign MemReadRequest = !Reset && (state == REQUEST) && !Redirect && !buffer_blocked;
    assign handshake      = MemReadRequest && MemReadReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state                 <= REQUEST;
            pc                    <= RESET_VECTOR;
            req_pc                <= RESET_VECTOR;
            discard               <= 1'b0;
            Instruction           <= 32'h0;
            InstructionPC         <= 32'h0;
            InstructionValid      <= 1'b0;
            MisalignedFetchSignal <= 1'b0;
        end else begin
            // Consume; a fill later in this block on the same edge overrides it.
            if (InstructionValid && !DecodeStall) begin
                InstructionValid <= 1'b0;
            end

            case (state)
                REQUEST: begin
                    // Returned data is not expected here (e.g. stray beat after reset).
                    if (Redirect) begin
                        pc               <= RedirectTarget;
                        InstructionValid <= 1'b0;
                        if (target_misaligned) begin
                            MisalignedFetchSignal <= 1'b1;
                            state                 <= HALT;
                        end
                    end else if (handshake) begin
                        req_pc <= pc;
                        state  <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    if (Redirect) begin
                        pc               <= RedirectTarget;
                        InstructionValid <= 1'b0;
                        if (target_misaligned) begin
                            MisalignedFetchSignal <= 1'b1;
                            discard               <= 1'b0;
                            state                 <= HALT;
                        end else if (MemReadDataValid) begin
                            // Wrong-path word lands on the redirect edge itself:
                            // drop it now, nothing left in flight to squash.
                            discard <= 1'b0;
                            state   <= REQUEST;
                        end else begin
                            // Wrong-path word still in flight: squash it on arrival.
                            discard <= 1'b1;
                        end
                    end else if (MemReadDataValid) begin
                        if (discard) begin
                            discard <= 1'b0;
                        end else begin
                            Instruction      <= MemReadData;
                            InstructionPC    <= req_pc;
                            InstructionValid <= 1'b1;
                            pc               <= pc + 32'd4;
                        end
                        state <= REQUEST;
                    end
                end

                HALT: begin
                    // Parked until reset; redirects and data are ignored.
                end

                default: begin
                    state <= REQUEST;
                end
            endcase
        end
    end

endmodule
